uart_telemetry_framer: RTL and testbench

Upstream feeder for the 115200-baud UART transmitter. On a request or a periodic tick it snapshots the microgreen sensor and status bytes and builds a fixed 7-byte telemetry frame. It streams the frame byte-by-byte into the transmitter's tx_data/tx_valid/tx_ready handshake.

---
 rtl/uart_telemetry_framer.sv | 158 +++++++++++++++
 tb/tb_uart_telemetry_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_telemetry_framer.sv
// uart_telemetry_framer: snapshots sensor/status bytes on a request or a
// periodic tick and streams a 7-byte frame
// (sync, seq, moisture, temperature, light, status, xor-checksum) into a
// byte-wide valid/ready UART transmitter interface.
module uart_telemetry_framer #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned PERIOD_CYCLES = 50000000,
  parameter int unsigned TIMER_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] moisture,
  input  logic [7:0] temperature,
  input  logic [7:0] light,
  input  logic [7:0] status,
  input  logic       send_req,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] seq,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t     state_q;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [7:0] byte_d;
  logic [7:0] checksum;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       busy_q;
  logic       frame_done_q;
  logic [7:0] seq_q;
  logic [7:0] drop_q;
  logic       pending_q;
  logic [7:0] snap_seq_q;
  logic [7:0] snap_moist_q;
  logic [7:0] snap_temp_q;
  logic [7:0] snap_light_q;
  logic [7:0] snap_stat_q;
  logic       tick;
  logic       trigger;

  if (PERIOD_CYCLES != 0) begin : g_timer
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(PERIOD_CYCLES - 1);
    logic [TIMER_W-1:0] timer_q;

    // Free-running period counter; frames never restart it.
    always_ff @(posedge clk) begin
      if (rst) begin
        timer_q <= '0;
      end else if (timer_q == LAST) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end

    assign tick = (timer_q == LAST);
  end else begin : g_no_timer
    assign tick = 1'b0;
  end

  // A request and a tick landing together are a single trigger.
  assign trigger  = send_req | tick;
  assign checksum = snap_seq_q ^ snap_moist_q ^ snap_temp_q ^ snap_light_q ^ snap_stat_q;
  assign idx_d    = idx_q + 3'd1;

  // Select the frame byte that follows the one currently offered.
  always_comb begin
    byte_d = SYNC_BYTE;
    case (idx_d)
      3'd1:    byte_d = snap_seq_q;
      3'd2:    byte_d = snap_moist_q;
      3'd3:    byte_d = snap_temp_q;
      3'd4:    byte_d = snap_light_q;
      3'd5:    byte_d = snap_stat_q;
      3'd6:    byte_d = checksum;
      default: byte_d = SYNC_BYTE;
    endcase
  end

  // Frame FSM with registered handshake outputs and trigger bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seq_q        <= 8'h00;
      drop_q       <= 8'h00;
      pending_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Only one trigger can be held back while a frame is running.
      if (trigger && state_q != IDLE) begin
        if (!pending_q) begin
          pending_q <= 1'b1;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end
      case (state_q)
        IDLE: begin
          if (trigger || pending_q) begin
            snap_seq_q   <= seq_q;
            snap_moist_q <= moisture;
            snap_temp_q  <= temperature;
            snap_light_q <= light;
            snap_stat_q  <= status;
            pending_q    <= 1'b0;
            idx_q        <= 3'd0;
            tx_data_q    <= SYNC_BYTE;
            tx_valid_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (tx_valid_q && tx_ready) begin
            if (idx_q == 3'd6) begin
              tx_valid_q   <= 1'b0;
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= byte_d;
            end
          end
        end
        DONE: begin
          seq_q   <= seq_q + 8'd1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign seq        = seq_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_telemetry_framer.sv
// Directed bench for uart_telemetry_framer: one request-driven instance with a
// paced transmitter model, one periodic instance with tx_ready tied high.
module tb_uart_telemetry_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // request-driven instance
  logic       rst0, req0, rdy0;
  logic [7:0] moist0, temp0, light0, stat0;
  logic [7:0] d0, seq0, drop0;
  logic       v0, busy0, fd0;

  // periodic instance
  logic       rst1;
  logic [7:0] d1, seq1, drop1;
  logic       v1, busy1, fd1;

  int n_vec = 0;
  int n_bad = 0;

  uart_telemetry_framer #(.SYNC_BYTE(8'hA5), .PERIOD_CYCLES(0), .TIMER_W(32)) dut0 (
    .clk(clk), .rst(rst0), .moisture(moist0), .temperature(temp0), .light(light0),
    .status(stat0), .send_req(req0), .tx_ready(rdy0), .tx_data(d0), .tx_valid(v0),
    .busy(busy0), .frame_done(fd0), .seq(seq0), .drop_count(drop0));

  uart_telemetry_framer #(.SYNC_BYTE(8'hA5), .PERIOD_CYCLES(1000), .TIMER_W(16)) dut1 (
    .clk(clk), .rst(rst1), .moisture(8'h11), .temperature(8'h22), .light(8'h33),
    .status(8'h44), .send_req(1'b0), .tx_ready(1'b1), .tx_data(d1), .tx_valid(v1),
    .busy(busy1), .frame_done(fd1), .seq(seq1), .drop_count(drop1));

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // transmitter model: 0 = ready 1 cycle in 10, 1 = ready low, 2 = ready high
  int          mode = 1;
  int unsigned cyc  = 0;
  initial begin
    rdy0 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
        0:       rdy0 = (cyc % 10 == 0);
        1:       rdy0 = 1'b0;
        default: rdy0 = 1'b1;
      endcase
    end
  end

  // accepted bytes and frame_done pulses of the request-driven instance
  logic [7:0] acc_q[$];
  int         fd_cnt = 0;
  always @(negedge clk) begin
    if (!rst0 && v0 && rdy0) acc_q.push_back(d0);
    if (!rst0 && fd0) fd_cnt++;
  end

  // frame start cycles of the periodic instance, counted from reset release
  int unsigned cnt1;
  int unsigned starts[$];
  logic [7:0]  start_seq[$];
  logic        v1_prev = 1'b0;
  always @(posedge clk) begin
    if (rst1) cnt1 <= 0;
    else      cnt1 <= cnt1 + 1;
  end
  always @(negedge clk) begin
    if (!rst1 && v1 && !v1_prev) begin
      starts.push_back(cnt1);
      start_seq.push_back(seq1);
    end
    v1_prev = v1;
  end

  task automatic pulse_req();
    @(posedge clk);
    #1 req0 = 1'b1;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (acc_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (acc_q.size() < n) check_vec(tag, acc_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy0) check_vec(tag, busy0, 0);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [55:0] exp);
    for (int i = 0; i < 7; i++)
      check_vec($sformatf("%s[%0d]", tag, i), acc_q[base + i], exp[55 - 8*i -: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_base;
    int stable;
    int k;
    rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0;
    moist0 = 8'h3C; temp0 = 8'h19; light0 = 8'h80; stat0 = 8'h05;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check_vec("rst_valid", v0, 0);
    check_vec("rst_data", d0, 8'h00);
    check_vec("rst_busy", busy0, 0);
    check_vec("rst_done", fd0, 0);
    check_vec("rst_seq", seq0, 8'h00);
    check_vec("rst_drop", drop0, 8'h00);

    // first frame, paced transmitter
    mode = 0; acc_q.delete();
    pulse_req();
    check_vec("lat_valid", v0, 1);
    check_vec("lat_sync", d0, 8'hA5);
    wait_bytes(7, "f1_bytes");
    check_frame("f1", 0, 56'hA5003C198005A0);
    wait_idle("f1_idle");
    repeat (2) @(negedge clk);
    check_vec("f1_done_cnt", fd_cnt, 1);
    check_vec("f1_seq", seq0, 8'h01);

    // second frame; input change after the request must not leak in
    acc_q.delete();
    pulse_req();
    moist0 = 8'hFF;
    wait_bytes(7, "f2_bytes");
    check_frame("f2", 0, 56'hA5013C198005A1);
    wait_idle("f2_idle");
    moist0 = 8'h3C;
    @(negedge clk);
    check_vec("f2_seq", seq0, 8'h02);

    // transmitter stalls for 50 cycles with byte [3] on offer
    acc_q.delete();
    pulse_req();
    wait_bytes(3, "f3_bytes3");
    mode = 1;
    stable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (v0 === 1'b1 && d0 === 8'h19) stable++;
    end
    check_vec("hold_stable", stable, 50);
    check_vec("hold_count", acc_q.size(), 3);
    mode = 0;
    wait_bytes(7, "f3_bytes");
    check_frame("f3", 0, 56'hA5023C198005A2);
    wait_idle("f3_idle");
    @(negedge clk);
    check_vec("f3_seq", seq0, 8'h03);

    // three back-to-back requests: start, pend, drop
    acc_q.delete(); fd_base = fd_cnt;
    @(posedge clk);
    #1 req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 req0 = 1'b0;
    wait_bytes(14, "pend_bytes");
    wait_idle("pend_idle");
    repeat (20) @(negedge clk);
    check_vec("pend_busy", busy0, 0);
    check_vec("pend_drop", drop0, 8'h01);
    check_vec("pend_frames", fd_cnt - fd_base, 2);
    check_vec("pend_seq", seq0, 8'h05);
    check_vec("pend_count", acc_q.size(), 14);
    check_frame("pend_a", 0, 56'hA5033C198005A3);
    check_frame("pend_b", 7, 56'hA5043C198005A4);

    // 301 sampled triggers with the transmitter stalled: drop count saturates
    mode = 1;
    @(posedge clk);
    #1 req0 = 1'b1;
    repeat (301) @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    check_vec("sat_drop", drop0, 8'hFF);
    check_vec("sat_busy", busy0, 1);

    // reset while byte [3] is on offer
    acc_q.delete(); mode = 0;
    wait_bytes(3, "mid_bytes");
    mode = 1;
    repeat (3) @(negedge clk);
    check_vec("mid_byte3", d0, 8'h19);
    @(posedge clk);
    #1 rst0 = 1'b1;
    @(posedge clk);
    #1 rst0 = 1'b0;
    @(negedge clk);
    check_vec("mid_rst_valid", v0, 0);
    check_vec("mid_rst_busy", busy0, 0);
    check_vec("mid_rst_seq", seq0, 8'h00);
    check_vec("mid_rst_drop", drop0, 8'h00);

    // fresh frame after reset, transmitter always ready
    mode = 2; acc_q.delete();
    pulse_req();
    check_vec("fresh_valid", v0, 1);
    check_vec("fresh_sync", d0, 8'hA5);
    wait_bytes(7, "fresh_bytes");
    check_frame("fresh", 0, 56'hA5003C198005A0);
    wait_idle("fresh_idle");
    @(negedge clk);
    check_vec("fresh_seq", seq0, 8'h01);

    // 255 more frames: seq runs 01..FF and wraps to 00
    for (int i = 0; i < 255; i++) begin
      acc_q.delete();
      pulse_req();
      wait_idle("wrap_idle");
    end
    @(negedge clk);
    check_vec("wrap_seq", seq0, 8'h00);
    check_frame("wrap_last", 0, 56'hA5FF3C1980055F);

    // periodic instance: frames start at cycles 1000, 2000, 3000
    k = 0;
    while (cnt1 < 3100 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check_vec("per_starts", starts.size() >= 3, 1);
    if (starts.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check_vec($sformatf("per_cycle%0d", i), starts[i], 1000 * (i + 1));
        check_vec($sformatf("per_seq%0d", i), start_seq[i], i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
